// File: rtl/mem_bus_wait_adapter_if.sv
// Bundle of master-side (CPU) and slave-side (RAM) bus signals around mem_bus_wait_adapter.
// The adapter takes the slave modport; the CPU/RAM environment takes the master modport.
interface mem_bus_wait_adapter_if;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [3:0]  s_byteenable;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    modport slave (
        input  m_address, m_read, m_write, m_byteenable, m_writedata,
        output m_waitrequest, m_readdata,
        output s_address, s_read, s_write, s_byteenable, s_writedata,
        input  s_readdata
    );

    modport master (
        output m_address, m_read, m_write, m_byteenable, m_writedata,
        input  m_waitrequest, m_readdata,
        input  s_address, s_read, s_write, s_byteenable, s_writedata,
        output s_readdata
    );
endinterface

// File: rtl/mem_bus_wait_adapter.sv
// Wait-state inserter between a CPU master and a zero-wait synchronous RAM; counts transactions.
// Define RANDOM_WAIT_EN to draw each stall length from an 8-bit LFSR instead of WAIT_CYCLES.
module mem_bus_wait_adapter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_bus_wait_adapter_if.slave   bus,
    output logic [31:0]             txn_count,
    output logic                    protocol_err
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [3:0]  be_reg, be_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        op_write_reg, op_write_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [31:0] txn_reg, txn_next;
    logic        perr_reg, perr_next;
    logic [7:0]  load_val;

`ifdef RANDOM_WAIT_EN
    localparam logic [7:0] SEED_FIX = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    logic [7:0] lfsr_reg, lfsr_next;
    logic       lfsr_fb;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1
    assign lfsr_fb  = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign load_val = {4'b0000, lfsr_reg[3:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_reg <= SEED_FIX;
        else       lfsr_reg <= lfsr_next;
    end
`else
    assign load_val = WAIT_LOAD;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            addr_reg     <= 32'd0;
            be_reg       <= 4'd0;
            wdata_reg    <= 32'd0;
            op_write_reg <= 1'b0;
            rdata_reg    <= 32'd0;
            txn_reg      <= 32'd0;
            perr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            be_reg       <= be_next;
            wdata_reg    <= wdata_next;
            op_write_reg <= op_write_next;
            rdata_reg    <= rdata_next;
            txn_reg      <= txn_next;
            perr_reg     <= perr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        be_next       = be_reg;
        wdata_next    = wdata_reg;
        op_write_next = op_write_reg;
        rdata_next    = rdata_reg;
        txn_next      = txn_reg;
        perr_next     = perr_reg;
`ifdef RANDOM_WAIT_EN
        lfsr_next     = lfsr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.m_read || bus.m_write) begin
                    addr_next     = bus.m_address;
                    be_next       = bus.m_byteenable;
                    wdata_next    = bus.m_writedata;
                    // Simultaneous read+write resolves to a write
                    op_write_next = bus.m_write;
                    perr_next     = perr_reg | (bus.m_read & bus.m_write);
                    cnt_next      = load_val;
                    state_next    = (load_val != 8'd0) ? WAIT : ACCESS;
`ifdef RANDOM_WAIT_EN
                    lfsr_next     = {lfsr_reg[6:0], lfsr_fb};
`endif
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 8'd1;
                if (cnt_reg == 8'd1) state_next = ACCESS;
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
                txn_next   = txn_reg + 32'd1;
                if (!op_write_reg) rdata_next = bus.s_readdata;
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM data lands during RESP; pass it through then, hold the captured copy afterwards
    assign bus.m_waitrequest = (state_reg != RESP);
    assign bus.m_readdata    = (state_reg == RESP && !op_write_reg) ? bus.s_readdata : rdata_reg;
    assign bus.s_address     = addr_reg;
    assign bus.s_byteenable  = be_reg;
    assign bus.s_writedata   = wdata_reg;
    assign bus.s_read        = (state_reg == ACCESS) && !op_write_reg;
    assign bus.s_write       = (state_reg == ACCESS) && op_write_reg;
    assign txn_count         = txn_reg;
    assign protocol_err      = perr_reg;
endmodule

// File: doc/mem_bus_wait_adapter.md
Name: mem_bus_wait_adapter

Overview:
- Sits between the mips_cpu_bus master port and a zero-wait synchronous RAM slave.
- Converts each master read/write into a held, wait-stated transaction on the master's waitrequest handshake.
- Purpose: exercise the CPU's stall logic under controlled (or pseudo-random) memory latency in testbenches.
- Also counts completed transactions and flags protocol violations.

Parameters:
- WAIT_CYCLES, 2, extra wait cycles inserted per transaction (0..255, 8-bit counter).
- LFSR_SEED, 8'hA5, reset seed for the optional random-wait LFSR; value 0 is replaced by 8'h01.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- m_address  input  32  master byte address
- m_read  input  1  master read request
- m_write  input  1  master write request
- m_byteenable  input  4  master byte lanes
- m_writedata  input  32  master write data
- m_waitrequest  output  1  high = transaction not yet accepted
- m_readdata  output  32  read data, valid when m_read high and m_waitrequest low
- s_address  output  32  slave address (latched copy)
- s_read  output  1  slave read strobe, one cycle
- s_write  output  1  slave write strobe, one cycle
- s_byteenable  output  4  slave byte lanes (latched)
- s_writedata  output  32  slave write data (latched)
- s_readdata  input  32  slave read data, valid the cycle after s_read
- txn_count  output  32  completed transactions, wraps at 2^32
- protocol_err  output  1  sticky: m_read and m_write seen high together

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all s_* outputs 0; m_readdata=0; txn_count=0; protocol_err=0; LFSR=seed.
  - m_waitrequest=1 while reset is high.
  - Any in-flight transaction is dropped, with no slave strobe.
- m_waitrequest is combinational: 0 only in state RESP, 1 in every other state, whether or not a request is present.
- States IDLE, WAIT, ACCESS, RESP:
  - IDLE: when m_read|m_write, latch address, byteenable, writedata and op; load counter=WAIT_CYCLES. Go to WAIT if counter>0, else ACCESS.
  - WAIT: decrement counter each cycle; go to ACCESS in the cycle the counter reaches 1 (i.e. W cycles spent in WAIT).
  - ACCESS: drive s_read or s_write high for exactly this cycle with latched fields; go to RESP.
  - RESP: capture s_readdata into m_readdata on entry (registered; holds until the next read). Go to IDLE and increment txn_count on the next clock edge.
- Latency with W wait cycles:
  - request first seen in cycle 0; m_waitrequest high for cycles 0..W+1; low in cycle W+2; next request sampled in IDLE at cycle W+3.
  - W=0 gives acceptance in cycle 2.
- Master fields changing after latch in IDLE are ignored until the next IDLE.
- A request dropped by the master mid-transaction (protocol violation) still completes on the slave; RESP still lasts one cycle.
- Read and write both high in IDLE: treated as a write; protocol_err set and held until reset.
- Writes leave m_readdata unchanged.
- txn_count wraps from 32'hFFFFFFFF to 0 without a flag.

Optional Feature:
- Macro: RANDOM_WAIT_EN.
- Defined:
  - counter load in IDLE = LFSR[3:0] (0..15) instead of WAIT_CYCLES.
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
  - LFSR advances once per transaction, on leaving IDLE.
- Undefined: LFSR logic absent; fixed WAIT_CYCLES latency.

Test Plan:
- WAIT_CYCLES=2; read 0x100 with RAM[0x100]=0xDEADBEEF → m_waitrequest high for 4 cycles, low in cycle 4, m_readdata=0xDEADBEEF, one s_read pulse, txn_count=1.
- WAIT_CYCLES=0; write 0x11223344 to 0x8, byteenable=4'b0011 → single s_write pulse in cycle 1 with be=0011, accepted in cycle 2; readback gives 0x00003344 (RAM pre-zeroed).
- Master changes m_address to 0x200 during WAIT of a read to 0x100 → s_address=0x100, data from 0x100.
- m_read=m_write=1 at 0x40 with data 0xA5A5A5A5 → s_write pulses, s_read never asserted, protocol_err=1 until reset.
- Reset asserted mid-WAIT → immediately m_waitrequest=1, s_read=s_write=0, txn_count=0; after release the next request takes the full W+2 stall.
- RANDOM_WAIT_EN defined, seed 8'hA5 → first transaction counter load = 5 (stall 7 cycles); following stalls follow the LFSR sequence, matching a bench reference model.
